// File: rtl/pw_checker.sv
// pw_checker: responder side of the comparator <-> checker handshake.
// It compares a latched register-file entry against the latched keypad code,
// one digit per cycle. The latency is fixed; there is no early exit on a mismatch.
module pw_checker #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        compare_start,
  input  logic [DIGITS*DIGIT_W:0]     stored_code,
  input  logic [DIGITS*DIGIT_W-1:0]   entered_code,
  output logic                        compare_done,
  output logic                        compare_match,
  output logic                        busy
);

  localparam int unsigned CODE_W = DIGITS * DIGIT_W;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                mismatch;
  logic [CODE_W:0]     stored_q;
  logic [CODE_W-1:0]   entered_q;

  logic [DIGIT_W-1:0]  cur_stored_c;
  logic [DIGIT_W-1:0]  cur_entered_c;
  logic                mismatch_next_c;

  // Select the digit addressed by idx from both latched operands (digit 0 = MSB digit).
  always_comb begin
    cur_stored_c  = '0;
    cur_entered_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_stored_c  = stored_q[CODE_W-1-i*DIGIT_W -: DIGIT_W];
        cur_entered_c = entered_q[CODE_W-1-i*DIGIT_W -: DIGIT_W];
      end
    end
    mismatch_next_c = mismatch | (cur_stored_c != cur_entered_c);
  end

  // Handshake FSM: latch operands at start, walk the digits, then hold the result until start drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      mismatch      <= 1'b0;
      stored_q      <= '0;
      entered_q     <= '0;
      compare_done  <= 1'b0;
      compare_match <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (compare_start) begin
            stored_q      <= stored_code;
            entered_q     <= entered_code;
            idx           <= '0;
            mismatch      <= 1'b0;
            compare_match <= 1'b0;
            busy          <= 1'b1;
            state         <= S_CMP;
          end
        end

        S_CMP: begin
          mismatch <= mismatch_next_c;
          if (idx == IDX_W'(DIGITS - 1)) begin
            // The final digit is folded in here, so the verdict includes it.
            idx           <= '0;
            busy          <= 1'b0;
            compare_done  <= 1'b1;
            compare_match <= stored_q[CODE_W] & ~mismatch_next_c;
            state         <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        S_DONE: begin
          if (!compare_start) begin
            compare_done <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          compare_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pw_checker.sv
// Directed self-checking bench for pw_checker.
module tb_pw_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        compare_start;
  logic [16:0] stored_code;
  logic [15:0] entered_code;
  logic        compare_done;
  logic        compare_match;
  logic        busy;

  int errors = 0;
  int checks = 0;

  pw_checker dut (
    .clk           (clk),
    .reset         (reset),
    .compare_start (compare_start),
    .stored_code   (stored_code),
    .entered_code  (entered_code),
    .compare_done  (compare_done),
    .compare_match (compare_match),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Run one request with start held high for the whole transaction (4-phase handshake).
  task automatic run_held(input string name, input logic [16:0] s, input logic [15:0] e,
                          input logic exp_match);
    stored_code   = s;
    entered_code  = e;
    compare_start = 1'b1;
    step();                                   // E0
    check({name, " busy@E0"}, busy, 1'b1);
    check({name, " match_clr@E0"}, compare_match, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check({name, " busy@cmp"}, busy, 1'b1);
      check({name, " done_early"}, compare_done, 1'b0);
    end
    step();                                   // E0+4
    check({name, " done@E0+4"}, compare_done, 1'b1);
    check({name, " match@E0+4"}, compare_match, exp_match);
    check({name, " busy@E0+4"}, busy, 1'b0);
    step();                                   // start still high: result held
    check({name, " done_hold"}, compare_done, 1'b1);
    check({name, " match_hold"}, compare_match, exp_match);
    compare_start = 1'b0;
    step();
    check({name, " done_drop"}, compare_done, 1'b0);
    check({name, " match_idle"}, compare_match, exp_match);
    step();
  endtask

  initial begin
    reset         = 1'b1;
    compare_start = 1'b0;
    stored_code   = '0;
    entered_code  = '0;

    // 1. reset for 2 cycles, then idle with start low
    step();
    step();
    reset = 1'b0;
    check("rst done", compare_done, 1'b0);
    check("rst match", compare_match, 1'b0);
    check("rst busy", busy, 1'b0);
    step();
    step();
    check("idle done", compare_done, 1'b0);
    check("idle busy", busy, 1'b0);

    // 2. matching code
    run_held("match", 17'h11234, 16'h1234, 1'b1);

    // 3. last digit differs, then first digit differs
    run_held("last_diff", 17'h11234, 16'h1235, 1'b0);
    run_held("first_diff", 17'h11234, 16'h2234, 1'b0);

    // 4. valid bit clear forces no match
    run_held("invalid", 17'h01234, 16'h1234, 1'b0);

    // 5. 1-cycle start pulse; operands change after E0
    stored_code   = 17'h1FFFF;
    entered_code  = 16'hFFFF;
    compare_start = 1'b1;
    step();                                   // E0
    compare_start = 1'b0;
    stored_code   = 17'h11111;
    entered_code  = 16'h0000;
    step();                                   // E0+1
    check("pulse busy@E0+1", busy, 1'b1);
    step();
    step();                                   // E0+3
    check("pulse done@E0+3", compare_done, 1'b0);
    step();                                   // E0+4
    check("pulse done@E0+4", compare_done, 1'b1);
    check("pulse match@E0+4", compare_match, 1'b1);
    step();                                   // E0+5
    check("pulse done@E0+5", compare_done, 1'b0);
    check("pulse match_idle", compare_match, 1'b1);
    step();

    // 6. reset mid-compare aborts; no done pulse follows
    stored_code   = 17'h11234;
    entered_code  = 16'h1234;
    compare_start = 1'b1;
    step();                                   // E0
    step();                                   // E0+1
    check("abort busy@E0+1", busy, 1'b1);
    reset         = 1'b1;
    compare_start = 1'b0;
    step();                                   // E0+2 with reset
    check("abort done", compare_done, 1'b0);
    check("abort match", compare_match, 1'b0);
    check("abort busy", busy, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("abort no_done", compare_done, 1'b0);
      check("abort no_busy", busy, 1'b0);
    end
    run_held("after_abort", 17'h1A5C3, 16'hA5C3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
